pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, PC field width.
REQ-002 The block SHALL have parameter DATA_W, default 32, width of inst, alu_out and ld_data fields.
REQ-003 The block SHALL have parameter NOP_INST, default 32'h00000013, bubble instruction encoding; the block SHALL require DATA_W >= 32.
REQ-004 The block SHALL have parameter CNT_W, default 16, backpressure counter width.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 flush  input  1  synchronous kill of all held entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  block accepts an entry this cycle.
REQ-010 in_pc_plus4 / in_inst / in_alu_out / in_ld_data  input  ADDR_W / DATA_W / DATA_W / DATA_W  upstream payload.
REQ-011 out_valid  output  1  head entry present.
REQ-012 out_ready  input  1  downstream consumes head.
REQ-013 out_pc_plus4 / out_inst / out_alu_out / out_ld_data  output  ADDR_W / DATA_W / DATA_W / DATA_W  head payload.
REQ-014 occupancy  output  2  number of held entries (0..2).
REQ-015 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 The block SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready, sampled at the rising edge.
REQ-017 The block SHALL implement states EMPTY (occupancy 0), ONE (head only) and TWO (head + skid), with occupancy encoding the state.
REQ-018 EMPTY: in_fire SHALL load the head register and move to ONE.
REQ-019 ONE: in_fire with out_fire SHALL replace the head and stay in ONE; in_fire alone SHALL load skid and move to TWO; out_fire alone SHALL move to EMPTY.
REQ-020 TWO: out_fire SHALL move skid into head and go to ONE; in_fire cannot occur.
REQ-021 in_ready SHALL be a registered output, equal to 1 in EMPTY and ONE and 0 in TWO, with no combinational path from out_ready.
REQ-022 out_valid SHALL be 1 exactly in ONE and TWO.
REQ-023 When out_valid=0, out_inst SHALL equal NOP_INST and the other payload outputs SHALL equal 0.
REQ-024 The block SHALL deliver entries in acceptance order with no loss or duplication; minimum in-to-out latency SHALL be 1 cycle.
REQ-025 flush=1 SHALL move to EMPTY on the next edge regardless of state, discard any same-cycle in_fire, and take priority over out_fire (bench does not count a flushed head as consumed).
REQ-026 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at 2^CNT_W-1, and be unaffected by flush.

Reset
REQ-027 rst=1 SHALL immediately force EMPTY: occupancy=0, out_valid=0, in_ready=1, out_inst=NOP_INST, other payload outputs=0, stall_cnt=0.
REQ-028 Reset asserted mid-transfer SHALL discard all held entries; the first edge after deassertion SHALL behave as in EMPTY.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined SHALL build the two-entry behaviour of REQ-017..REQ-021.
REQ-030 Without PIPE_STAGE_SKID_EN the block SHALL have no skid register: states EMPTY/ONE only, occupancy <= 1, in_ready = ~out_valid | out_ready (combinational), in ONE in_fire with out_fire replaces the head; all other requirements unchanged.

Verification
REQ-031 Reset release, in_valid=0 -> out_valid=0, out_inst=32'h00000013, in_ready=1, occupancy=0, stall_cnt=0.
REQ-032 Stream inst 0x1..0x8 with out_ready=1 every cycle -> out_inst 0x1..0x8 in order, one per cycle, 1-cycle latency, occupancy stays 1.
REQ-033 (SKID_EN) Accept 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0 next cycle, stall_cnt increments per cycle; raise out_ready -> 0xA then 0xB delivered.
REQ-034 Occupancy 2 with flush=1 and in_valid=1 (inst 0xC) -> next cycle occupancy=0, out_valid=0, out_inst=NOP; 0xC never appears.
REQ-035 Hold out_valid=1, out_ready=0 for 70000 cycles with CNT_W=16 -> stall_cnt saturates at 65535.
REQ-036 Assert rst asynchronously between edges at occupancy 2 -> outputs reach reset values before the next edge; stall_cnt=0.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: head register plus optional skid entry.
// Define PIPE_STAGE_SKID_EN for the two-entry registered-ready build.
module pipe_stage_buf #(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc_plus4,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_ld_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc_plus4,
  output logic [DATA_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_ld_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // DATA_W must be at least 32 so the bubble encoding fits out_inst.
  typedef struct packed {
    logic [ADDR_W-1:0] pc_plus4;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] ld_data;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  ent_t       head_q;
  ent_t       in_ent;
  logic       in_fire;
  logic       out_fire;
  logic       ld_head_in;
  logic       ld_head_skid;
  logic       ld_skid;
  logic [CNT_W-1:0] stall_q;

  assign in_ent = '{
    pc_plus4: in_pc_plus4,
    inst:     in_inst,
    alu_out:  in_alu_out,
    ld_data:  in_ld_data
  };

  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_q;

`ifdef PIPE_STAGE_SKID_EN
  ent_t skid_q;
  logic in_ready_q;

  assign in_ready = in_ready_q;
`else
  assign in_ready = ~out_valid | out_ready;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and load enables; flush overrides everything
  always_comb begin
    state_d      = state_q;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          ld_head_in = 1'b1;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          ld_head_in = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
        end else if (in_fire) begin
          ld_skid = 1'b1;
          state_d = TWO;
`endif
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      TWO: begin
        if (out_fire) begin
          ld_head_skid = 1'b1;
          state_d      = ONE;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d      = EMPTY;
      ld_head_in   = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // Head payload register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
    end else if (ld_head_in) begin
      head_q <= in_ent;
`ifdef PIPE_STAGE_SKID_EN
    end else if (ld_head_skid) begin
      head_q <= skid_q;
`endif
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid payload register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          skid_q <= '0;
    else if (ld_skid) skid_q <= in_ent;
  end

  // Ready is registered from next state: low only while full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready_q <= 1'b1;
    else     in_ready_q <= (state_d != TWO);
  end
`else
  logic unused_skid;
  assign unused_skid = ld_head_skid | ld_skid;
`endif

  // Saturating backpressure counter, independent of flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready &&
                 stall_q != {CNT_W{1'b1}}) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;

  // Bubble out a NOP with zero payload when nothing is held
  always_comb begin
    out_pc_plus4 = '0;
    out_inst     = DATA_W'(NOP_INST);
    out_alu_out  = '0;
    out_ld_data  = '0;
    if (out_valid) begin
      out_pc_plus4 = head_q.pc_plus4;
      out_inst     = head_q.inst;
      out_alu_out  = head_q.alu_out;
      out_ld_data  = head_q.ld_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf with a queue-based model.
// Handles both the default and PIPE_STAGE_SKID_EN builds.
module tb_pipe_stage_buf;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [31:0] NOP = 32'h00000013;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc_plus4;
  logic [DATA_W-1:0] in_inst;
  logic [DATA_W-1:0] in_alu_out;
  logic [DATA_W-1:0] in_ld_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc_plus4;
  logic [DATA_W-1:0] out_inst;
  logic [DATA_W-1:0] out_alu_out;
  logic [DATA_W-1:0] out_ld_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int errs   = 0;
  int checks = 0;
  logic [31:0] q[$];
  logic [CNT_W-1:0] mcnt = '0;

  pipe_stage_buf #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .NOP_INST(NOP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus4(in_pc_plus4), .in_inst(in_inst),
    .in_alu_out(in_alu_out), .in_ld_data(in_ld_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_plus4(out_pc_plus4), .out_inst(out_inst),
    .out_alu_out(out_alu_out), .out_ld_data(out_ld_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_W-1:0] pc_of(input logic [31:0] i);
    return ADDR_W'(i * 4 + 4);
  endfunction
  function automatic logic [DATA_W-1:0] alu_of(input logic [31:0] i);
    return i ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [DATA_W-1:0] ld_of(input logic [31:0] i);
    return i + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input logic mv, input logic mir,
                         input logic [31:0] h);
    chk("out_valid", 64'(out_valid), 64'(mv));
    chk("in_ready", 64'(in_ready), 64'(mir));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("out_inst", 64'(out_inst), 64'(mv ? h : NOP));
    chk("out_pc", 64'(out_pc_plus4), 64'(mv ? pc_of(h) : '0));
    chk("out_alu", 64'(out_alu_out), 64'(mv ? alu_of(h) : '0));
    chk("out_ld", 64'(out_ld_data), 64'(mv ? ld_of(h) : '0));
    chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
  endtask

  // One cycle: drive, optionally check, clock, update model
  task automatic step(input logic iv, input logic [31:0] inst,
                      input logic ordy, input logic fl, input bit c);
    logic mv;
    logic mir;
    logic [31:0] h;
    in_valid    = iv;
    in_inst     = inst;
    in_pc_plus4 = pc_of(inst);
    in_alu_out  = alu_of(inst);
    in_ld_data  = ld_of(inst);
    out_ready   = ordy;
    flush       = fl;
    #1;
    mv = (q.size() > 0);
`ifdef PIPE_STAGE_SKID_EN
    mir = (q.size() < 2);
`else
    mir = !mv || ordy;
`endif
    h = mv ? q[0] : NOP;
    if (c) chk_out(mv, mir, h);
    @(posedge clk);
    if (mv && !ordy && mcnt != {CNT_W{1'b1}}) mcnt++;
    if (fl) begin
      q.delete();
    end else begin
      if (mv && ordy) void'(q.pop_front());
      if (iv && mir) q.push_back(inst);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc_plus4 = '0; in_alu_out = '0; in_ld_data = '0;
    #2;
    chk_out(1'b0, 1'b1, NOP);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Full-rate stream, 1-cycle latency
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Backpressure: fill, hold, then drain
    step(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hB, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Flush while full with a competing input and ready downstream
    step(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h21, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'hC, 1'b1, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    // Flush with one held entry and a stall in the same cycle
    step(1'b1, 32'h22, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'hC, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Counter saturation
    step(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 70000; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("stall_sat", 64'(stall_cnt), 64'hFFFF);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset between edges while full
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h41, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    q.delete();
    mcnt = '0;
    chk_out(1'b0, 1'b1, NOP);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h50, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
